// File: rtl/rv32_pipe_ctrl.sv
// rv32_pipe_ctrl: control unit for a three-stage RV32 pipeline (FD -> EX -> MW).
//
// Decodes the FD instruction into a control record. The record moves through
// the EX and MW control registers. The unit detects load-use hazards and resolves
// taken branches. It also counts the instructions that retire from MW.
//
// Ports
//   clk       in   system clock; all state updates on the rising edge
//   rst_n     in   synchronous active-low reset
//   inst      in   [31:0] instruction in the FD stage
//   alu_zero  in   ALU result-equals-zero flag for the EX stage
//   ctrl      out  [0:12] control vector:
//                  [0] pc_sel, [1] reg_we, [2:4] imm_type, [5] alu_src,
//                  [6:8] alu_op, [9] mem_we, [10] wb_sel, [11] pc_hold, [12] flush
//   illegal   out  one-cycle pulse while an unsupported instruction sits in EX
//   retired   out  [15:0] wrapping count of instructions retired from MW
module rv32_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        alu_zero,
    output logic [0:12] ctrl,
    output logic        illegal,
    output logic [15:0] retired
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSll = 3'b110;
    localparam logic [2:0] AluSrl = 3'b111;

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StStall = 2'd2;
    localparam logic [1:0] StFlush = 2'd3;

    // An all-zero record is a bubble.
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_we;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_we;
        logic       wb_sel;
        logic       is_load;
        logic       is_branch;
        logic       is_bne;
        logic [4:0] rd;
    } ex_ctl_t;

    // Maps funct3 to the ALU operation for R and I-ALU instructions. sltu
    // folds onto slt. sra folds onto srl.
    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic sub_sel);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub_sel ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSlt;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    logic [1:0]  state_q, state_d;
    ex_ctl_t     ex_q, ex_d, fd_ctl;
    logic        mw_valid_q, mw_reg_we_q, mw_mem_we_q, mw_wb_sel_q;
    logic [15:0] retired_q;

    logic [6:0]  opcode;
    logic [4:0]  fd_rd, fd_rs1, fd_rs2;
    logic [2:0]  fd_funct3;
    logic [2:0]  fd_imm;
    logic        fd_uses_rs2;
    logic        taken, hazard, boot;

    assign opcode    = inst[6:0];
    assign fd_rd     = inst[11:7];
    assign fd_funct3 = inst[14:12];
    assign fd_rs1    = inst[19:15];
    assign fd_rs2    = inst[24:20];

    logic unused_inst;
    assign unused_inst = ^{inst[31], inst[29:25]};

    // FD decode
    always_comb begin
        fd_ctl      = '0;
        fd_imm      = ImmI;
        fd_uses_rs2 = 1'b0;
        case (opcode)
            OpR: begin
                fd_ctl.valid  = 1'b1;
                fd_ctl.rd     = fd_rd;
                fd_ctl.reg_we = (fd_rd != 5'd0);
                fd_ctl.alu_op = alu_funct(fd_funct3, inst[30]);
                fd_uses_rs2   = 1'b1;
            end
            OpImm: begin
                fd_ctl.valid   = 1'b1;
                fd_ctl.rd      = fd_rd;
                fd_ctl.reg_we  = (fd_rd != 5'd0);
                fd_ctl.alu_src = 1'b1;
                fd_ctl.alu_op  = alu_funct(fd_funct3, 1'b0);
            end
            OpLoad: begin
                fd_ctl.valid   = 1'b1;
                fd_ctl.rd      = fd_rd;
                fd_ctl.reg_we  = (fd_rd != 5'd0);
                fd_ctl.alu_src = 1'b1;
                fd_ctl.alu_op  = AluAdd;
                fd_ctl.wb_sel  = 1'b1;
                fd_ctl.is_load = 1'b1;
            end
            OpStore: begin
                fd_ctl.valid   = 1'b1;
                fd_ctl.alu_src = 1'b1;
                fd_ctl.alu_op  = AluAdd;
                fd_ctl.mem_we  = 1'b1;
                fd_imm         = ImmS;
                fd_uses_rs2    = 1'b1;
            end
            OpBranch: begin
                fd_imm      = ImmB;
                fd_uses_rs2 = 1'b1;
                if (fd_funct3[2:1] == 2'b00) begin
                    fd_ctl.valid     = 1'b1;
                    fd_ctl.alu_op    = AluSub;
                    fd_ctl.is_branch = 1'b1;
                    fd_ctl.is_bne    = fd_funct3[0];
                end else begin
                    fd_ctl.illegal = 1'b1;
                end
            end
            default: fd_ctl.illegal = 1'b1;
        endcase
    end

    assign boot  = (state_q == StBoot);
    // BEQ takes on zero. BNE takes on non-zero.
    assign taken = ex_q.valid & ex_q.is_branch & (alu_zero ^ ex_q.is_bne);
    assign hazard = ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0) &
                    ((fd_rs1 == ex_q.rd) | (fd_uses_rs2 & (fd_rs2 == ex_q.rd)));

    always_comb begin
        state_d = StRun;
        case (state_q)
            StBoot:  state_d = StRun;
            StRun: begin
                if (taken) begin
                    state_d = StFlush;
                end else if (hazard) begin
                    state_d = StStall;
                end
            end
            // EX holds a bubble in both states, so nothing can redirect here.
            StStall: state_d = StRun;
            StFlush: state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // The FD instruction reaches EX only when it is neither held nor squashed.
    assign ex_d = (boot | taken | hazard) ? '0 : fd_ctl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            ex_q        <= '0;
            mw_valid_q  <= 1'b0;
            mw_reg_we_q <= 1'b0;
            mw_mem_we_q <= 1'b0;
            mw_wb_sel_q <= 1'b0;
            retired_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mw_valid_q  <= ex_q.valid;
            mw_reg_we_q <= ex_q.reg_we;
            mw_mem_we_q <= ex_q.mem_we;
            mw_wb_sel_q <= ex_q.wb_sel;
            if (mw_valid_q) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // While reset is asserted, everything except the FD imm_type reads zero.
    always_comb begin
        ctrl      = '0;
        ctrl[2:4] = fd_imm;
        if (rst_n) begin
            ctrl[0]   = taken;
            ctrl[1]   = mw_reg_we_q;
            ctrl[5]   = ex_q.alu_src;
            ctrl[6:8] = ex_q.alu_op;
            ctrl[9]   = mw_mem_we_q;
            ctrl[10]  = mw_wb_sel_q;
            ctrl[11]  = boot | (hazard & ~taken);
            ctrl[12]  = taken;
        end
    end

    assign illegal = rst_n & ex_q.illegal;
    assign retired = retired_q;

endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// Testbench for rv32_pipe_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-level pipeline model.
module tb_rv32_pipe_ctrl;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        alu_zero;
    logic [0:12] ctrl;
    logic        illegal;
    logic [15:0] retired;

    always #5 clk = ~clk;

    rv32_pipe_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst     (inst),
        .alu_zero (alu_zero),
        .ctrl     (ctrl),
        .illegal  (illegal),
        .retired  (retired)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // One in-flight instruction as the model sees it.
    typedef struct packed {
        bit       valid;
        bit       illegal;
        bit       we;
        bit       src;
        bit       store;
        bit       load;
        bit       br;
        bit       bne;
        bit [2:0] op;
        bit [4:0] rd;
    } minst_t;

    minst_t      m_ex = '0;
    minst_t      m_mw = '0;
    bit          m_boot = 1'b1;
    logic [15:0] m_ret = 16'd0;

    logic [0:12] obs_ctrl, exp_ctrl;
    logic        obs_ill, exp_ill;
    logic [15:0] obs_ret, exp_ret;
    bit          exp_hold;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [2:0] m_alu(input logic [2:0] f3, input logic sub_sel);
        case (f3)
            3'd0:    return sub_sel ? 3'b001 : 3'b000;
            3'd1:    return 3'b110;
            3'd2:    return 3'b101;
            3'd3:    return 3'b101;
            3'd4:    return 3'b100;
            3'd5:    return 3'b111;
            3'd6:    return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] m_imm(input logic [6:0] opc);
        if (opc == OpStore) return 3'b001;
        if (opc == OpBranch) return 3'b010;
        return 3'b000;
    endfunction

    function automatic minst_t m_decode(input logic [31:0] w);
        minst_t     d;
        logic [6:0] opc;
        opc = w[6:0];
        d   = '0;
        if (opc == OpR || opc == OpImm || opc == OpLoad) begin
            d.valid = 1'b1;
            d.rd    = w[11:7];
            d.we    = (w[11:7] != 5'd0);
        end
        if (opc == OpR) d.op = m_alu(w[14:12], w[30]);
        if (opc == OpImm) begin
            d.src = 1'b1;
            d.op  = m_alu(w[14:12], 1'b0);
        end
        if (opc == OpLoad) begin
            d.src  = 1'b1;
            d.load = 1'b1;
        end
        if (opc == OpStore) begin
            d.valid = 1'b1;
            d.src   = 1'b1;
            d.store = 1'b1;
        end
        if (opc == OpBranch) begin
            if (w[14:12] == 3'b000 || w[14:12] == 3'b001) begin
                d.valid = 1'b1;
                d.br    = 1'b1;
                d.bne   = w[12];
                d.op    = 3'b001;
            end else begin
                d.illegal = 1'b1;
            end
        end
        if (!(opc inside {OpR, OpImm, OpLoad, OpStore, OpBranch})) d.illegal = 1'b1;
        return d;
    endfunction

    // Drive one cycle. Capture the DUT outputs and the model's expectations,
    // then advance the model across the rising edge.
    task automatic cycle(input logic [31:0] i, input logic az, input logic rst);
        minst_t     fd;
        bit         taken, hazard, uses2;
        logic [4:0] rs1, rs2;
        @(negedge clk);
        inst     = i;
        alu_zero = az;
        rst_n    = rst;
        #1;
        obs_ctrl = ctrl;
        obs_ill  = illegal;
        obs_ret  = retired;
        fd    = m_decode(i);
        rs1   = i[19:15];
        rs2   = i[24:20];
        uses2 = (i[6:0] == OpR) || (i[6:0] == OpStore) || (i[6:0] == OpBranch);
        taken = m_ex.valid && m_ex.br && (m_ex.bne ? !az : az);
        hazard = m_ex.valid && m_ex.load && (m_ex.rd != 5'd0) &&
                 ((rs1 == m_ex.rd) || (uses2 && rs2 == m_ex.rd));
        exp_ctrl      = '0;
        exp_ctrl[2:4] = m_imm(i[6:0]);
        exp_hold      = 1'b0;
        exp_ill       = 1'b0;
        if (rst) begin
            exp_hold      = m_boot || (hazard && !taken);
            exp_ctrl[0]   = taken;
            exp_ctrl[1]   = m_mw.valid && m_mw.we;
            exp_ctrl[5]   = m_ex.src;
            exp_ctrl[6:8] = m_ex.op;
            exp_ctrl[9]   = m_mw.valid && m_mw.store;
            exp_ctrl[10]  = m_mw.valid && m_mw.load;
            exp_ctrl[11]  = exp_hold;
            exp_ctrl[12]  = taken;
            exp_ill       = m_ex.illegal;
        end
        exp_ret = m_ret;
        if (!rst) begin
            m_ex   = '0;
            m_mw   = '0;
            m_boot = 1'b1;
            m_ret  = 16'd0;
        end else begin
            if (m_mw.valid) m_ret = m_ret + 16'd1;
            m_mw = m_ex;
            if (m_boot || taken || hazard) m_ex = '0;
            else m_ex = fd;
            m_boot = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic apply_reset();
        cycle(mk(OpImm, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0), 1'b0, 1'b0);
        cycle(mk(OpImm, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0), 1'b0, 1'b0);
    endtask

    logic [31:0] nop, add1, lw5, add6, beq, bne, victim, bad, badbr;

    task automatic test_reset();
        logic [0:12] masked;
        cycle(mk(OpImm, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0), 1'b0, 1'b0);
        cycle(mk(OpStore, 5'd1, 3'd2, 5'd2, 5'd3, 7'd0), 1'b1, 1'b0);
        masked      = obs_ctrl;
        masked[2:4] = 3'b000;
        n_checks++;
        if (masked !== 13'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0 outside imm_type", obs_ctrl);
        end
        n_checks++;
        if (obs_ctrl[2:4] !== 3'b001) begin
            n_fail++; $display("FAIL reset_imm: got %b want 001", obs_ctrl[2:4]);
        end
        n_checks++;
        if (obs_ill !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b want 0", obs_ill);
        end
        n_checks++;
        if (obs_ret !== 16'd0) begin
            n_fail++; $display("FAIL reset_retired: got %h want 0000", obs_ret);
        end
    endtask

    task automatic test_basic_add();
        apply_reset();
        cycle(add1, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[11] !== 1'b1) begin
            n_fail++; $display("FAIL boot_hold: got %b want 1", obs_ctrl[11]);
        end
        cycle(add1, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[11] !== 1'b0) begin
            n_fail++; $display("FAIL run_hold: got %b want 0", obs_ctrl[11]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl !== exp_ctrl) begin
            n_fail++; $display("FAIL add_ex_ctrl: got %b want %b", obs_ctrl, exp_ctrl);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[1] !== 1'b1 || obs_ctrl[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL add_mw: got we=%b wb=%b want we=1 wb=0", obs_ctrl[1], obs_ctrl[10]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ret !== 16'd1) begin
            n_fail++; $display("FAIL add_retired: got %0d want 1", obs_ret);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        cycle(lw5, 1'b0, 1'b1);
        cycle(lw5, 1'b0, 1'b1);
        cycle(add6, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[11] !== 1'b1 || obs_ctrl[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_hazard: got hold=%b src=%b want 1 1", obs_ctrl[11], obs_ctrl[5]);
        end
        cycle(add6, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[11] !== 1'b0 || obs_ctrl[5:8] !== 4'b0000) begin
            n_fail++;
            $display("FAIL lu_bubble: got hold=%b ex=%b want 0 0000", obs_ctrl[11], obs_ctrl[5:8]);
        end
        n_checks++;
        if (obs_ctrl[1] !== 1'b1 || obs_ctrl[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_load_mw: got we=%b wb=%b want 1 1", obs_ctrl[1], obs_ctrl[10]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[1] !== 1'b0 || obs_ctrl[11] !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_mw_bubble: got we=%b hold=%b want 0 0", obs_ctrl[1], obs_ctrl[11]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[1] !== 1'b1 || obs_ctrl[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_add_late: got we=%b wb=%b want 1 0", obs_ctrl[1], obs_ctrl[10]);
        end
    endtask

    task automatic test_branch_taken();
        apply_reset();
        cycle(beq, 1'b0, 1'b1);
        cycle(beq, 1'b0, 1'b1);
        cycle(victim, 1'b1, 1'b1);
        n_checks++;
        if (obs_ctrl[0] !== 1'b1 || obs_ctrl[12] !== 1'b1 || obs_ctrl[11] !== 1'b0 ||
            obs_ctrl[6:8] !== 3'b001) begin
            n_fail++;
            $display("FAIL beq_taken: got sel=%b flush=%b hold=%b op=%b want 1 1 0 001",
                     obs_ctrl[0], obs_ctrl[12], obs_ctrl[11], obs_ctrl[6:8]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[0] !== 1'b0 || obs_ctrl[12] !== 1'b0 || obs_ctrl[5:8] !== 4'b0000) begin
            n_fail++;
            $display("FAIL beq_bubble: got sel=%b flush=%b ex=%b want 0 0 0000",
                     obs_ctrl[0], obs_ctrl[12], obs_ctrl[5:8]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ret !== 16'd1) begin
            n_fail++; $display("FAIL beq_retired: got %0d want 1", obs_ret);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ret !== 16'd1 || obs_ctrl[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_squash: got retired=%0d we=%b want 1 0", obs_ret, obs_ctrl[1]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ret !== 16'd2) begin
            n_fail++; $display("FAIL beq_after: got %0d want 2", obs_ret);
        end
    endtask

    task automatic test_bne_not_taken();
        apply_reset();
        cycle(bne, 1'b0, 1'b1);
        cycle(bne, 1'b0, 1'b1);
        cycle(victim, 1'b1, 1'b1);
        n_checks++;
        if (obs_ctrl[0] !== 1'b0 || obs_ctrl[12] !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_sel: got sel=%b flush=%b want 0 0", obs_ctrl[0], obs_ctrl[12]);
        end
        cycle(nop, 1'b1, 1'b1);
        n_checks++;
        if (obs_ctrl !== exp_ctrl) begin
            n_fail++; $display("FAIL bne_next: got %b want %b", obs_ctrl, exp_ctrl);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[1] !== 1'b1) begin
            n_fail++; $display("FAIL bne_follow_we: got %b want 1", obs_ctrl[1]);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        cycle(bad, 1'b0, 1'b1);
        cycle(bad, 1'b0, 1'b1);
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ill !== 1'b1) begin
            n_fail++; $display("FAIL ill_pulse: got %b want 1", obs_ill);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ill !== 1'b0 || obs_ctrl[1] !== 1'b0 || obs_ctrl[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_mw: got ill=%b we=%b mwe=%b want 0 0 0",
                     obs_ill, obs_ctrl[1], obs_ctrl[9]);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ret !== 16'd0) begin
            n_fail++; $display("FAIL ill_retired: got %0d want 0", obs_ret);
        end
        cycle(badbr, 1'b0, 1'b1);
        cycle(nop, 1'b1, 1'b1);
        n_checks++;
        if (obs_ill !== 1'b1 || obs_ctrl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_branch_f3: got ill=%b sel=%b want 1 0", obs_ill, obs_ctrl[0]);
        end
    endtask

    task automatic test_reset_in_stall();
        logic [0:12] masked;
        apply_reset();
        cycle(lw5, 1'b0, 1'b1);
        cycle(lw5, 1'b0, 1'b1);
        cycle(add6, 1'b0, 1'b1);
        cycle(add6, 1'b0, 1'b0);
        masked      = obs_ctrl;
        masked[2:4] = 3'b000;
        n_checks++;
        if (masked !== 13'd0 || obs_ill !== 1'b0) begin
            n_fail++; $display("FAIL stall_rst_mask: got %b ill=%b want 0", obs_ctrl, obs_ill);
        end
        cycle(add6, 1'b0, 1'b1);
        n_checks++;
        if (obs_ctrl[11] !== 1'b1 || obs_ctrl[1] !== 1'b0 || obs_ctrl[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_rst_boot: got hold=%b we=%b mwe=%b want 1 0 0",
                     obs_ctrl[11], obs_ctrl[1], obs_ctrl[9]);
        end
    endtask

    task automatic test_retired_wrap();
        apply_reset();
        cycle(nop, 1'b0, 1'b1);
        for (int k = 0; k < 70000 && exp_ret != 16'hFFFF; k++) begin
            cycle(nop, 1'b0, 1'b1);
        end
        n_checks++;
        if (obs_ret !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_full: got %h want ffff", obs_ret);
        end
        cycle(nop, 1'b0, 1'b1);
        n_checks++;
        if (obs_ret !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero: got %h want 0000", obs_ret);
        end
    endtask

    function automatic logic [31:0] gen();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: return mk(OpR, rd, f3, rs1, rs2, ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00);
            1: return mk(OpImm, rd, f3, rs1, 5'($urandom), 7'($urandom));
            2, 3: return mk(OpLoad, rd, 3'd2, rs1, 5'($urandom), 7'($urandom));
            4: return mk(OpStore, 5'($urandom), 3'd2, rs1, rs2, 7'($urandom));
            5: return mk(OpBranch, 5'($urandom), 3'($urandom_range(0, 1)), rs1, rs2, 7'd0);
            6: return mk(OpBranch, 5'($urandom), 3'($urandom_range(2, 7)), rs1, rs2, 7'd0);
            default: begin
                case ($urandom_range(0, 3))
                    0: return mk(7'h7F, rd, f3, rs1, rs2, 7'd0);
                    1: return mk(7'b0001111, rd, f3, rs1, rs2, 7'd0);
                    2: return mk(7'b1101111, rd, f3, rs1, rs2, 7'd0);
                    default: return mk(7'b0110111, rd, f3, rs1, rs2, 7'd0);
                endcase
            end
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] cur;
        logic        rst, az;
        apply_reset();
        cur = gen();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            az  = 1'($urandom_range(0, 1));
            cycle(cur, az, rst);
            n_checks++;
            if (obs_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: inst=%h got %b want %b", n, cur, obs_ctrl, exp_ctrl);
            end
            n_checks++;
            if (obs_ill !== exp_ill) begin
                n_fail++; $display("FAIL rand_illegal[%0d]: got %b want %b", n, obs_ill, exp_ill);
            end
            n_checks++;
            if (obs_ret !== exp_ret) begin
                n_fail++; $display("FAIL rand_retired[%0d]: got %0d want %0d", n, obs_ret, exp_ret);
            end
            // A held fetch re-presents the same instruction.
            if (!exp_hold) cur = gen();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        inst     = 32'd0;
        alu_zero = 1'b0;
        nop    = mk(OpImm, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0);
        add1   = mk(OpR, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0);
        lw5    = mk(OpLoad, 5'd5, 3'd2, 5'd1, 5'd0, 7'd0);
        add6   = mk(OpR, 5'd6, 3'd0, 5'd5, 5'd2, 7'd0);
        beq    = mk(OpBranch, 5'd0, 3'd0, 5'd7, 5'd8, 7'd0);
        bne    = mk(OpBranch, 5'd0, 3'd1, 5'd7, 5'd8, 7'd0);
        victim = mk(OpR, 5'd9, 3'd0, 5'd2, 5'd3, 7'd0);
        bad    = mk(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0);
        badbr  = mk(OpBranch, 5'd0, 3'd2, 5'd7, 5'd8, 7'd0);
        test_reset();
        test_basic_add();
        test_load_use();
        test_branch_taken();
        test_bne_not_taken();
        test_illegal();
        test_reset_in_stall();
        test_random();
        test_retired_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_pipe_ctrl.md
RV32_PIPE_CTRL -- requirements
Module: rv32_pipe_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of clk.
REQ-002 SHALL expose: clk  in  1  system clock.
REQ-003 SHALL expose: rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL expose: inst  in  32  instruction currently in the fetch/decode (FD) stage.
REQ-005 SHALL expose: alu_zero  in  1  ALU result-equals-zero flag for the execute (EX) stage.
REQ-006 SHALL expose: ctrl  out  [0:12]  datapath control vector.
- [0] pc_sel
- [1] reg_we
- [2:4] imm_type
- [5] alu_src
- [6:8] alu_op
- [9] mem_we
- [10] wb_sel
- [11] pc_hold
- [12] flush
REQ-007 SHALL expose: illegal  out  1  pulse, one cycle, when an unsupported opcode enters EX.
REQ-008 SHALL expose: retired  out  16  count of instructions completing memory/writeback (MW).

Function
REQ-009 SHALL decode these FD opcodes; any other opcode SHALL decode as a bubble with an illegal tag.
- R 0110011
- I-ALU 0010011
- LOAD 0000011
- STORE 0100011
- BRANCH 1100011 (funct3 000 BEQ, 001 BNE; any other funct3 is illegal)
REQ-010 SHALL encode imm_type as 000 I, 001 S, 010 B.
REQ-011 SHALL encode alu_op as 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- LOAD and STORE use add.
- BRANCH uses sub.
REQ-012 SHALL drive ctrl[2:4] combinationally from the FD decode.
- ctrl[5:8] comes from the EX control register.
- ctrl[1], ctrl[9] and ctrl[10] come from the MW control register.
REQ-013 SHALL advance decoded control FD->EX->MW one stage per cycle; a bubble is all-zero control with valid=0.
REQ-014 SHALL assert ctrl[0] and ctrl[12] combinationally when EX holds a valid branch that is taken.
- BEQ is taken when alu_zero=1.
- BNE is taken when alu_zero=0.
REQ-015 On a taken branch, the FD instruction SHALL be squashed, so EX receives a bubble on the next edge.
REQ-016 SHALL detect a load-use hazard when all of the following hold:
- EX holds a valid LOAD with rd!=0.
- FD rs1 equals that rd, or FD rs2 equals that rd and the FD instruction uses rs2 (R, STORE, BRANCH).
REQ-017 On a load-use hazard, SHALL assert ctrl[11] (PC and FD hold) and insert a bubble into EX for exactly one cycle.
REQ-018 A taken branch and a hazard in the same cycle SHALL resolve as branch: ctrl[11]=0 and ctrl[12]=1.
REQ-019 SHALL implement FSM states BOOT, RUN, STALL and FLUSH.
- BOOT->RUN after one cycle; BOOT emits a bubble into EX with ctrl[11]=1.
- RUN->STALL on a hazard.
- RUN->FLUSH on a taken branch.
- STALL->RUN unconditionally.
- FLUSH->RUN unconditionally.
- FLUSH with a new taken branch in EX is impossible and SHALL go to RUN.
REQ-020 SHALL increment retired when a valid non-illegal instruction leaves MW; it wraps 0xFFFF->0x0000.
REQ-021 SHALL never assert ctrl[1] for rd=0 or for a STORE or BRANCH.

Reset
REQ-022 When rst_n=0 at an edge, SHALL set state=BOOT, clear EX/MW control registers to bubble, and set retired=0.
REQ-023 During reset, all ctrl bits except [2:4] SHALL read 0, and illegal SHALL read 0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight stages; no MW write (ctrl[1], ctrl[9]) SHALL occur in the cycle after the reset edge.

Verification
REQ-025 Reset release, then feed add x1,x2,x3 -> BOOT cycle has ctrl[11]=1; two cycles after RUN entry ctrl[1]=1 and ctrl[10]=0; retired=1 one cycle later.
REQ-026 lw x5,0(x1) followed by add x6,x5,x2 -> exactly one cycle with ctrl[11]=1; EX sees a bubble; add reaches EX one cycle late.
REQ-027 beq with alu_zero=1 in EX -> ctrl[0]=1 and ctrl[12]=1 that cycle; next EX is a bubble; retired does not count the squashed instruction.
REQ-028 bne with alu_zero=1 -> ctrl[0]=0; following instruction proceeds normally.
REQ-029 Opcode 1111111 -> illegal pulses for 1 cycle in EX; ctrl[1]=ctrl[9]=0 in MW; retired unchanged.
REQ-030 Force retired=0xFFFF and retire one instruction -> retired=0x0000; rst_n=0 during a stall -> next cycle state BOOT and ctrl[1]=0.
